// File: rtl/dram_port_arb_pkg.sv
// Shared definitions for the dram port arbiter.
//   arb_state_e : arbiter FSM encoding (ST_ARB / ST_LOCK)
//   BURST_W     : width of the burst-lock run counter (holds 0..16)
//   id_width()  : requester-ID width, never narrower than one bit
package dram_port_arb_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int BURST_W = 5;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_port_arb_rr_arbiter.sv
// Round-robin grant selection, purely combinational.
// Picks the first requesting index at or after ptr_i, wrapping at NUM_REQ-1.
//   req_i  : request vector
//   ptr_i  : round-robin start index (always < NUM_REQ)
//   gnt_o  : one-hot grant, zero when req_i is zero
//   idx_o  : binary index of the grant (0 when no grant)
module dram_port_arb_rr_arbiter
  import dram_port_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  logic found;
  int   k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/dram_port_arb.sv
// Round-robin arbiter sharing one dram port between NUM_REQ requesters,
// with optional burst lock. Grants are combinational; accepted accesses are
// registered onto the dram port one cycle later, and read data comes back
// two cycles after the accept tagged with the requester ID.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_i/lock_i/we_i     : per-requester request, burst lock, write enable
//   addr_i/wdata_i        : flattened per-requester address / write data
//   gnt_o                 : one-hot grant
//   mem_*_o, mem_rd_data_i: dram port
//   rd_vld_o/rd_id_o/rd_data_o : returned read data
// Optional build macro DRAM_ARB_STATS_EN adds stall_cnt_o and gnt_cnt_o
// (saturating 16-bit stall-cycle and per-requester accept counters).
//
// state   | meaning
// ST_ARB  | round-robin among all requesters from rr_ptr
// ST_LOCK | only the burst owner may be granted
module dram_port_arb
  import dram_port_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  WIDTH     = 32,
  parameter int  DEPTH     = 32,
  parameter int  MAX_BURST = 4,
  localparam int ADDR      = $clog2(DEPTH),
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      lock_i,
  input  logic [NUM_REQ-1:0]      we_i,
  input  logic [NUM_REQ*ADDR-1:0] addr_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [ADDR-1:0]         mem_addr_o,
  output logic                    mem_wr_en_o,
  output logic [WIDTH-1:0]        mem_wr_data_o,
  output logic                    mem_rd_en_o,
  input  logic [WIDTH-1:0]        mem_rd_data_i,
  output logic                    rd_vld_o,
  output logic [ID_W-1:0]         rd_id_o,
  output logic [WIDTH-1:0]        rd_data_o
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [15:0]             stall_cnt_o,
  output logic [NUM_REQ*16-1:0]   gnt_cnt_o
`endif
);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [ADDR-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic               mem_wr_en_q, mem_wr_en_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic [ID_W-1:0]    issue_id_q, issue_id_d;
  logic               rd_vld_q, rd_vld_d;
  logic [ID_W-1:0]    rd_id_q, rd_id_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               accept;
  logic [BURST_W-1:0] burst_inc;

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] i);
    return (i == ID_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  dram_port_arb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Grant is held off while reset is asserted so nothing is accepted then.
  always_comb begin
    gnt     = '0;
    gnt_idx = arb_idx;
    if (state_q == ST_LOCK) begin
      gnt_idx      = owner_q;
      gnt[owner_q] = req_i[owner_q];
    end else begin
      gnt = arb_gnt;
    end
    if (rst_i) gnt = '0;
  end

  assign accept    = |gnt;
  assign burst_inc = burst_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_ARB: begin
        if (accept) begin
          rr_ptr_d = ptr_after(gnt_idx);
          // A single-beat burst limit means locking can never extend a grant.
          if (lock_i[gnt_idx] && MAX_BURST > 1) begin
            state_d = ST_LOCK;
            owner_d = gnt_idx;
            burst_d = BURST_W'(1);
          end
        end
      end
      ST_LOCK: begin
        if (accept) begin
          burst_d = burst_inc;
          if (!lock_i[owner_q] || burst_inc == BURST_W'(MAX_BURST)) begin
            state_d  = ST_ARB;
            burst_d  = '0;
            rr_ptr_d = ptr_after(owner_q);
          end
        end else begin
          // Owner withdrew its request: release the lock without a grant.
          state_d  = ST_ARB;
          burst_d  = '0;
          rr_ptr_d = ptr_after(owner_q);
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    mem_wr_en_d   = accept & we_i[gnt_idx];
    mem_rd_en_d   = accept & ~we_i[gnt_idx];
    mem_addr_d    = accept ? addr_i[int'(gnt_idx)*ADDR +: ADDR] : mem_addr_q;
    mem_wr_data_d = accept ? wdata_i[int'(gnt_idx)*WIDTH +: WIDTH] : mem_wr_data_q;
    issue_id_d    = accept ? gnt_idx : issue_id_q;
    rd_vld_d      = mem_rd_en_q;
    rd_id_d       = issue_id_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_ARB;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      burst_q       <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      issue_id_q    <= '0;
      rd_vld_q      <= 1'b0;
      rd_id_q       <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_q       <= burst_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      issue_id_q    <= issue_id_d;
      rd_vld_q      <= rd_vld_d;
      rd_id_q       <= rd_id_d;
    end
  end

  assign gnt_o         = gnt;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign mem_rd_en_o   = mem_rd_en_q;
  assign rd_vld_o      = rd_vld_q;
  assign rd_id_o       = rd_id_q;
  assign rd_data_o     = mem_rd_data_i;

`ifdef DRAM_ARB_STATS_EN
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic [NUM_REQ*16-1:0] gnt_cnt_q, gnt_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    gnt_cnt_d   = gnt_cnt_q;
    if ((req_i & ~gnt) != '0 && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k] && gnt_cnt_q[k*16 +: 16] != 16'hFFFF)
        gnt_cnt_d[k*16 +: 16] = gnt_cnt_q[k*16 +: 16] + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      gnt_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      gnt_cnt_q   <= gnt_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign gnt_cnt_o   = gnt_cnt_q;
`endif

endmodule
